knn_topk: RTL

- Downstream consumer of the squared-distance core.
- Accepts a stream of (squared distance, class label) pairs, one per test-vs-training comparison, and keeps the K smallest in a sorted on-chip list.
- After the last pair, runs a sequential majority vote over the kept labels and presents the winning class to the peripheral register interface.

---
 rtl/knn_topk_if.sv | 44 ++++
 rtl/knn_topk.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/knn_topk_if.sv
// Pair-stream and result bundle for knn_topk; master drives pairs, slave is the top-K block.
// With KNN_TOPK_DIST_OUT_EN defined it also carries the sorted-slot debug read port.
interface knn_topk_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned K       = 4,
  parameter int unsigned LABEL_W = 8
) ();
  localparam int unsigned VW = $clog2(K + 1);

  logic                  clear;
  logic                  in_valid;
  logic                  in_ready;
  logic [2*DATA_W-1:0]   in_dist;
  logic [LABEL_W-1:0]    in_label;
  logic                  in_last;
  logic                  done;
  logic [LABEL_W-1:0]    label_out;
  logic [VW-1:0]         votes_out;
`ifdef KNN_TOPK_DIST_OUT_EN
  // Index is wide enough to express out-of-range values (>= K)
  logic [VW-1:0]         rd_idx;
  logic [2*DATA_W-1:0]   rd_dist;
  logic [LABEL_W-1:0]    rd_label;
  logic                  rd_valid;

  modport master (
    output clear, in_valid, in_dist, in_label, in_last, rd_idx,
    input  in_ready, done, label_out, votes_out, rd_dist, rd_label, rd_valid
  );
  modport slave (
    input  clear, in_valid, in_dist, in_label, in_last, rd_idx,
    output in_ready, done, label_out, votes_out, rd_dist, rd_label, rd_valid
  );
`else
  modport master (
    output clear, in_valid, in_dist, in_label, in_last,
    input  in_ready, done, label_out, votes_out
  );
  modport slave (
    input  clear, in_valid, in_dist, in_label, in_last,
    output in_ready, done, label_out, votes_out
  );
`endif
endinterface

// File: rtl/knn_topk.sv
// knn_topk: keeps the K smallest (distance, label) pairs sorted, then majority-votes their labels.
// Optional debug read port of the sorted list enabled by defining KNN_TOPK_DIST_OUT_EN.
module knn_topk #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned K       = 4,
  parameter int unsigned LABEL_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  knn_topk_if.slave bus
);
  localparam int unsigned DW = 2 * DATA_W;
  localparam int unsigned VW = $clog2(K + 1);

  typedef enum logic [1:0] {StCollect, StVote, StDone} state_e;

  state_e               r_state, w_state_nxt;
  logic [DW-1:0]        r_dist  [K];
  logic [LABEL_W-1:0]   r_label [K];
  logic [K-1:0]         r_valid;
  logic [VW-1:0]        r_idx;
  logic                 r_cand_ok;
  logic [LABEL_W-1:0]   r_cand_label;
  logic [VW-1:0]        r_cand_cnt;
  logic [LABEL_W-1:0]   r_best_label;
  logic [VW-1:0]        r_best_cnt;
  logic [LABEL_W-1:0]   r_label_out;
  logic [VW-1:0]        r_votes_out;

  logic                 w_in_ready;
  logic                 w_xfer;
  logic [K-1:0]         w_gt;
  logic [K-1:0]         w_first;
  logic [DW-1:0]        w_dist_ins  [K];
  logic [LABEL_W-1:0]   w_label_ins [K];
  logic [K-1:0]         w_valid_ins;
  logic                 w_cand_ok;
  logic [LABEL_W-1:0]   w_cand_label;
  logic [VW-1:0]        w_cand_cnt;
  logic [LABEL_W-1:0]   w_best_label_nxt;
  logic [VW-1:0]        w_best_cnt_nxt;

  assign w_in_ready = (r_state == StCollect);
  assign w_xfer     = bus.in_valid && w_in_ready && !bus.clear;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StCollect: if (w_xfer && bus.in_last) w_state_nxt = StVote;
      StVote:    if (r_idx == VW'(K)) w_state_nxt = StDone;
      StDone:    w_state_nxt = StDone;
      default:   w_state_nxt = StCollect;
    endcase
    if (bus.clear) w_state_nxt = StCollect;
  end

  // Valid slots form a sorted prefix, so w_gt is monotone and w_first is one-hot or zero.
  always_comb begin
    for (int j = 0; j < K; j++) begin
      w_gt[j] = !r_valid[j] || (r_dist[j] > bus.in_dist);
    end
    w_first[0] = w_gt[0];
    for (int j = 1; j < K; j++) begin
      w_first[j] = w_gt[j] && !w_gt[j-1];
    end
    for (int j = 0; j < K; j++) begin
      w_dist_ins[j]  = r_dist[j];
      w_label_ins[j] = r_label[j];
      w_valid_ins[j] = r_valid[j];
      if (w_first[j]) begin
        w_dist_ins[j]  = bus.in_dist;
        w_label_ins[j] = bus.in_label;
        w_valid_ins[j] = 1'b1;
      end
    end
    for (int j = 1; j < K; j++) begin
      if (w_gt[j] && !w_first[j]) begin
        w_dist_ins[j]  = r_dist[j-1];
        w_label_ins[j] = r_label[j-1];
        w_valid_ins[j] = r_valid[j-1];
      end
    end
  end

  // Vote count for candidate slot r_idx; registered, then compared one cycle later.
  always_comb begin
    w_cand_ok    = 1'b0;
    w_cand_label = '0;
    w_cand_cnt   = '0;
    for (int j = 0; j < K; j++) begin
      if (VW'(j) == r_idx) begin
        w_cand_ok    = r_valid[j];
        w_cand_label = r_label[j];
      end
    end
    for (int j = 0; j < K; j++) begin
      if (r_valid[j] && (r_label[j] == w_cand_label)) w_cand_cnt = w_cand_cnt + VW'(1);
    end
  end

  always_comb begin
    w_best_label_nxt = r_best_label;
    w_best_cnt_nxt   = r_best_cnt;
    if (r_cand_ok && (r_cand_cnt > r_best_cnt)) begin
      w_best_label_nxt = r_cand_label;
      w_best_cnt_nxt   = r_cand_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StCollect;
      r_valid      <= '0;
      r_idx        <= '0;
      r_cand_ok    <= 1'b0;
      r_cand_label <= '0;
      r_cand_cnt   <= '0;
      r_best_label <= '0;
      r_best_cnt   <= '0;
      r_label_out  <= '0;
      r_votes_out  <= '0;
      for (int j = 0; j < K; j++) begin
        r_dist[j]  <= '0;
        r_label[j] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (bus.clear) begin
        r_valid <= '0;
      end else if (w_xfer) begin
        r_valid <= w_valid_ins;
        for (int j = 0; j < K; j++) begin
          r_dist[j]  <= w_dist_ins[j];
          r_label[j] <= w_label_ins[j];
        end
      end
      if ((r_state == StVote) && !bus.clear) begin
        r_idx        <= r_idx + VW'(1);
        r_cand_ok    <= w_cand_ok;
        r_cand_label <= w_cand_label;
        r_cand_cnt   <= w_cand_cnt;
        r_best_label <= w_best_label_nxt;
        r_best_cnt   <= w_best_cnt_nxt;
        if (r_idx == VW'(K)) begin
          r_label_out <= w_best_label_nxt;
          r_votes_out <= w_best_cnt_nxt;
        end
      end else begin
        r_idx        <= '0;
        r_cand_ok    <= 1'b0;
        r_best_label <= '0;
        r_best_cnt   <= '0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.done      = (r_state == StDone);
  assign bus.label_out = r_label_out;
  assign bus.votes_out = r_votes_out;

`ifdef KNN_TOPK_DIST_OUT_EN
  always_comb begin
    bus.rd_valid = 1'b0;
    bus.rd_dist  = '0;
    bus.rd_label = '0;
    for (int j = 0; j < K; j++) begin
      if (VW'(j) == bus.rd_idx) begin
        bus.rd_valid = r_valid[j];
        bus.rd_dist  = r_dist[j];
        bus.rd_label = r_label[j];
      end
    end
  end
`endif

endmodule
